// File: rtl/exu_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exu_lsu_pkg
// Purpose : Shared encodings for the execute-stage load/store unit.
//           - Access-size codes, used by the decoder and the LSU.
//           - FSM state encoding.
//           - Small decode helpers for size.
// Rev     : 1.0  initial release
// ============================================================================
package exu_lsu_pkg;

  localparam int LSU_SIZE_WIDTH  = 2;
  localparam int LSU_STATE_WIDTH = 2;

  localparam logic [LSU_SIZE_WIDTH-1:0] LSU_B = 2'b00;
  localparam logic [LSU_SIZE_WIDTH-1:0] LSU_H = 2'b01;
  localparam logic [LSU_SIZE_WIDTH-1:0] LSU_W = 2'b10;
  localparam logic [LSU_SIZE_WIDTH-1:0] LSU_D = 2'b11;

  typedef enum logic [LSU_STATE_WIDTH-1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } lsu_state_e;

  // Number of bytes touched by an access of the given size (1, 2, 4 or 8).
  function automatic logic [3:0] lsu_nbytes(input logic [LSU_SIZE_WIDTH-1:0] size);
    return 4'd1 << size;
  endfunction

  // Address low bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] lsu_align_mask(input logic [LSU_SIZE_WIDTH-1:0] size);
    logic [2:0] m;
    case (size)
      LSU_B:   m = 3'b000;
      LSU_H:   m = 3'b001;
      LSU_W:   m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lane_align
// Purpose : Combinational byte-lane steering for the LSU.
//   i_off      : byte offset of the access inside the bus word
//   i_size     : access size code
//   i_wdata    : right-aligned store data
//   i_rdata    : raw bus read data
//   o_wdata    : store data shifted to its byte lanes
//   o_wmask    : byte-lane write strobes
//   o_rdata    : read data shifted down and zero-extended to the access size
// Rev     : 1.0  initial release
// ============================================================================
module lsu_lane_align
  import exu_lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = 2
) (
  input  logic [OFF_W-1:0]          i_off,
  input  logic [LSU_SIZE_WIDTH-1:0] i_size,
  input  logic [XLEN-1:0]           i_wdata,
  input  logic [XLEN-1:0]           i_rdata,
  output logic [XLEN-1:0]           o_wdata,
  output logic [XLEN/8-1:0]         o_wmask,
  output logic [XLEN-1:0]           o_rdata
);

  localparam int LANES = XLEN / 8;

  logic [3:0]       w_nbytes;
  logic [LANES-1:0] w_lane;
  logic [XLEN-1:0]  w_dmask;
  logic [XLEN-1:0]  w_rshift;

  assign w_nbytes = lsu_nbytes(i_size);

  // Lanes [0, nbytes) are the ones covered by the access before shifting.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_lane[i]          = (4'(i) < w_nbytes);
    assign w_dmask[8*i +: 8]  = {8{w_lane[i]}};
  end

  assign o_wdata  = i_wdata << {i_off, 3'b000};
  assign o_wmask  = w_lane << i_off;
  assign w_rshift = i_rdata >> {i_off, 3'b000};
  // Masking after the shift keeps bytes beyond the access out of the result.
  assign o_rdata  = w_rshift & w_dmask;

endmodule
`default_nettype wire

// File: rtl/exu_lsu.sv
`default_nettype none
// ============================================================================
// Module  : exu_lsu
// Purpose : Execute-stage load/store unit. Accepts one access from the EXU,
//           runs it over a valid/ready memory bus and returns zero-extended,
//           lane-corrected load data.
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/req_ready              : EXU request handshake
//   req_we/req_size/req_addr/req_wdata : access descriptor
//   mem_req_valid/mem_req_ready      : bus request handshake
//   mem_we/mem_addr/mem_wdata/mem_wmask : bus request payload
//   mem_rsp_valid/mem_rdata          : bus response (read data or write ack)
//   done/mem_r/misalign              : completion pulse, load data, fault flag
// Rev     : 1.0  initial release
// ============================================================================
module exu_lsu
  import exu_lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [LSU_SIZE_WIDTH-1:0] req_size,
  input  logic [XLEN-1:0]           req_addr,
  input  logic [XLEN-1:0]           req_wdata,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_we,
  output logic [XLEN-1:0]           mem_addr,
  output logic [XLEN-1:0]           mem_wdata,
  output logic [XLEN/8-1:0]         mem_wmask,
  input  logic                      mem_rsp_valid,
  input  logic [XLEN-1:0]           mem_rdata,
  output logic                      done,
  output logic [XLEN-1:0]           mem_r,
  output logic                      misalign
);

  lsu_state_e r_state;
  lsu_state_e w_state_nxt;

  logic                      r_we;
  logic [LSU_SIZE_WIDTH-1:0] r_size;
  logic [XLEN-1:0]           r_addr;
  logic [XLEN-1:0]           r_wdata;
  logic                      r_mis;
  logic [XLEN-1:0]           r_mem_r;

  logic                      w_accept;
  logic                      w_mis;
  logic [XLEN-1:0]           w_wdata_sh;
  logic [XLEN/8-1:0]         w_wmask;
  logic [XLEN-1:0]           w_rdata_al;

  assign w_accept = req_valid && (r_state == ST_IDLE);

  // Unaligned offset, or a doubleword on a 32-bit datapath.
  assign w_mis = (|(req_addr[2:0] & lsu_align_mask(req_size))) ||
                 ((req_size == LSU_D) && (XLEN == 32));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt = w_mis ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture and load-data register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_size  <= LSU_B;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mis   <= 1'b0;
      r_mem_r <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_mis   <= w_mis;
      end
      // Responses are only honoured in WAIT_RSP; stray ones elsewhere drop.
      if ((r_state == ST_WAIT_RSP) && mem_rsp_valid) begin
        r_mem_r <= r_we ? '0 : w_rdata_al;
      end
    end
  end

  lsu_lane_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_lane_align (
    .i_off   (r_addr[OFF_W-1:0]),
    .i_size  (r_size),
    .i_wdata (r_wdata),
    .i_rdata (mem_rdata),
    .o_wdata (w_wdata_sh),
    .o_wmask (w_wmask),
    .o_rdata (w_rdata_al)
  );

  // Bus payload comes straight from the captured request, so it cannot move
  // while REQ waits for mem_req_ready.
  assign req_ready     = (r_state == ST_IDLE);
  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_we        = r_we;
  assign mem_addr      = {r_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata     = w_wdata_sh;
  assign mem_wmask     = r_we ? w_wmask : '0;
  assign done          = (r_state == ST_DONE);
  assign misalign      = (r_state == ST_DONE) && r_mis;
  assign mem_r         = r_mem_r;

endmodule
`default_nettype wire
